// File: rtl/rx_link_fault_ctrl_if.sv
// XGMII receive word plus link-fault status bundle between the RX datapath and the fault
// controller.
interface rx_link_fault_ctrl_if;
    logic [63:0] rxd64;
    logic [7:0]  rxc8;
    logic        rs_enable;
    logic [1:0]  link_fault;
    logic [1:0]  tx_fault_ctrl;
    logic        fault_change;
    logic        seq_detect;

    modport master (
        output rxd64, rxc8, rs_enable,
        input  link_fault, tx_fault_ctrl, fault_change, seq_detect
    );

    modport slave (
        input  rxd64, rxc8, rs_enable,
        output link_fault, tx_fault_ctrl, fault_change, seq_detect
    );
endinterface

// File: rtl/rx_link_fault_ctrl.sv
// Link fault detector for the 10G RS receive path: counts local/remote fault ordered sets
// per XGMII column and drives the link_fault code and TX fault-response command.
module rx_link_fault_ctrl #(
    parameter int unsigned COL_WINDOW = 128,
    parameter int unsigned SEQ_THRESH = 4
) (
    input logic                 rxclk_in,
    input logic                 reset_in,
    rx_link_fault_ctrl_if.slave rx_if
);

    typedef enum logic [1:0] {StInit, StCount, StFault} state_e;

    typedef struct packed {
        state_e     st;
        logic [7:0] col_cnt;
        logic [2:0] seq_cnt;
        logic [1:0] last_type;
        logic [1:0] fault;
    } ctx_t;

    localparam ctx_t CtxReset = '{
        st: StInit, col_cnt: 8'd0, seq_cnt: 3'd0, last_type: 2'b00, fault: 2'b00
    };

    localparam logic [7:0] ColWindow = 8'(COL_WINDOW);
    localparam logic [2:0] SeqThresh = 3'(SEQ_THRESH);

    function automatic logic col_is_seq(logic [31:0] d, logic [3:0] c);
        return (d[31:24] == 8'h9c) && (c == 4'b1000) && (d[23:8] == 16'h0000) &&
               ((d[7:0] == 8'h01) || (d[7:0] == 8'h02));
    endfunction

    // Fault type code equals the low two bits of the fourth lane: 01 local, 10 remote.
    function automatic ctx_t col_step(ctx_t c, logic is_seq, logic [1:0] typ);
        ctx_t n;
        n = c;
        if (is_seq) begin
            n.col_cnt = 8'd0;
            case (c.st)
                StInit: begin
                    n.st        = StCount;
                    n.last_type = typ;
                    n.seq_cnt   = 3'd1;
                end
                StCount: begin
                    if (typ == c.last_type) begin
                        n.seq_cnt = c.seq_cnt + 3'd1;
                        if (n.seq_cnt == SeqThresh) begin
                            n.st    = StFault;
                            n.fault = c.last_type;
                        end
                    end else begin
                        n.last_type = typ;
                        n.seq_cnt   = 3'd1;
                    end
                end
                StFault: begin
                    if (typ != c.last_type) begin
                        n.st        = StCount;
                        n.last_type = typ;
                        n.seq_cnt   = 3'd1;
                    end
                end
                default: n = CtxReset;
            endcase
        end else begin
            if (c.col_cnt < ColWindow) begin
                n.col_cnt = c.col_cnt + 8'd1;
            end
            if ((c.st != StInit) && (n.col_cnt == ColWindow)) begin
                n.st      = StInit;
                n.seq_cnt = 3'd0;
                n.fault   = 2'b00;
            end
        end
        return n;
    endfunction

    ctx_t       ctx_q, ctx_d, ctx_mid;
    logic [1:0] tx_q, tx_d;
    logic       fc_q, fc_d;
    logic       sd_q, sd_d;
    logic       seq0, seq1;

    assign seq0 = col_is_seq(rx_if.rxd64[63:32], rx_if.rxc8[7:4]);
    assign seq1 = col_is_seq(rx_if.rxd64[31:0], rx_if.rxc8[3:0]);

    always_comb begin
        ctx_mid = col_step(ctx_q, seq0, rx_if.rxd64[33:32]);
        ctx_d   = col_step(ctx_mid, seq1, rx_if.rxd64[1:0]);
        sd_d    = seq0 | seq1;
        if (!rx_if.rs_enable) begin
            ctx_d = CtxReset;
            sd_d  = 1'b0;
        end
        fc_d = (ctx_d.fault != ctx_q.fault);
        case (ctx_d.fault)
            2'b01:   tx_d = 2'b01;
            2'b10:   tx_d = 2'b10;
            default: tx_d = 2'b00;
        endcase
    end

    always_ff @(posedge rxclk_in) begin
        if (reset_in) begin
            ctx_q <= CtxReset;
            tx_q  <= 2'b00;
            fc_q  <= 1'b0;
            sd_q  <= 1'b0;
        end else begin
            ctx_q <= ctx_d;
            tx_q  <= tx_d;
            fc_q  <= fc_d;
            sd_q  <= sd_d;
        end
    end

    assign rx_if.link_fault    = ctx_q.fault;
    assign rx_if.tx_fault_ctrl = tx_q;
    assign rx_if.fault_change  = fc_q;
    assign rx_if.seq_detect    = sd_q;

endmodule

// File: tb/tb_rx_link_fault_ctrl.sv
// Directed plus randomized bench for rx_link_fault_ctrl against a run-length reference model.
module tb_rx_link_fault_ctrl;

    localparam int Window = 128;
    localparam int Thresh = 4;

    localparam logic [63:0] IdleD = 64'h0707070707070707;
    localparam logic [7:0]  IdleC = 8'hff;
    localparam logic [63:0] LocD  = 64'h9c00000107070707;
    localparam logic [63:0] RemD  = 64'h9c00000207070707;
    localparam logic [63:0] ResD  = 64'h9c00000307070707;
    localparam logic [7:0]  Col0C = 8'h8f;
    localparam logic [63:0] DualD = 64'h9c0000019c000001;
    localparam logic [7:0]  DualC = 8'h88;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rx_link_fault_ctrl_if bus ();

    rx_link_fault_ctrl #(
        .COL_WINDOW(Window),
        .SEQ_THRESH(Thresh)
    ) dut (
        .rxclk_in(clk),
        .reset_in(rst),
        .rx_if   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: length of the current same-type run of sequence columns and the gap since the last.
    int         m_gap;
    int         m_run_len;
    logic [1:0] m_run_type;
    logic [1:0] m_lf;
    logic       m_fc;
    logic       m_sd;

    function automatic logic [1:0] col_kind(logic [31:0] d, logic [3:0] c);
        if (d[31:24] == 8'h9c && c == 4'b1000 && d[23:8] == 16'h0) begin
            if (d[7:0] == 8'h01) return 2'b01;
            if (d[7:0] == 8'h02) return 2'b10;
        end
        return 2'b00;
    endfunction

    task automatic model_clear();
        m_gap = 0;
        m_run_len = 0;
        m_run_type = 2'b00;
        m_lf = 2'b00;
        m_sd = 1'b0;
    endtask

    task automatic model_col(input logic [1:0] k);
        if (k != 2'b00) begin
            m_sd = 1'b1;
            m_gap = 0;
            if (m_run_len > 0 && k == m_run_type) m_run_len++;
            else begin
                m_run_type = k;
                m_run_len = 1;
            end
            if (m_run_len >= Thresh) m_lf = m_run_type;
        end else if (m_gap < Window) begin
            m_gap++;
            if (m_gap == Window) begin
                m_run_len = 0;
                m_lf = 2'b00;
            end
        end
    endtask

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [63:0] d, input logic [7:0] c, input logic en,
                        input logic r);
        logic [1:0] prev;
        logic [1:0] exp_tx;
        bus.rxd64 = d;
        bus.rxc8 = c;
        bus.rs_enable = en;
        rst = r;
        @(posedge clk);
        #1;
        prev = m_lf;
        m_sd = 1'b0;
        if (r) begin
            model_clear();
            m_fc = 1'b0;
        end else if (!en) begin
            model_clear();
            m_fc = (prev != 2'b00);
        end else begin
            model_col(col_kind(d[63:32], c[7:4]));
            model_col(col_kind(d[31:0], c[3:0]));
            m_fc = (m_lf != prev);
        end
        exp_tx = (m_lf == 2'b01) ? 2'b01 : (m_lf == 2'b10) ? 2'b10 : 2'b00;
        check("link_fault", bus.link_fault, m_lf);
        check("tx_fault_ctrl", bus.tx_fault_ctrl, exp_tx);
        check("fault_change", {1'b0, bus.fault_change}, {1'b0, m_fc});
        check("seq_detect", {1'b0, bus.seq_detect}, {1'b0, m_sd});
    endtask

    task automatic rand_col(input int kind, output logic [31:0] d, output logic [3:0] c);
        case (kind)
            0:       begin d = 32'h9c000001; c = 4'b1000; end
            1:       begin d = 32'h9c000002; c = 4'b1000; end
            2:       begin d = 32'h9c000003; c = 4'b1000; end
            3:       begin d = 32'h9c000001; c = 4'b1100; end
            4:       begin d = 32'h07070707; c = 4'b1111; end
            default: begin d = $urandom; c = 4'b0000; end
        endcase
    endtask

    initial begin
        logic [31:0] d0, d1;
        logic [3:0]  c0, c1;
        int          fav;
        bus.rxd64 = IdleD;
        bus.rxc8 = IdleC;
        bus.rs_enable = 1'b1;
        model_clear();

        repeat (10) step(IdleD, IdleC, 1'b1, 1'b1);

        repeat (4) step(LocD, Col0C, 1'b1, 1'b0);
        check("plan_local_col0", bus.link_fault, 2'b01);

        step(IdleD, IdleC, 1'b1, 1'b1);
        repeat (2) step(DualD, DualC, 1'b1, 1'b0);
        check("plan_dual_fault", bus.link_fault, 2'b01);
        repeat (63) step(IdleD, IdleC, 1'b1, 1'b0);
        check("plan_dual_hold", bus.link_fault, 2'b01);
        step(IdleD, IdleC, 1'b1, 1'b0);
        check("plan_dual_clear", bus.link_fault, 2'b00);

        step(IdleD, IdleC, 1'b1, 1'b1);
        repeat (3) step(LocD, Col0C, 1'b1, 1'b0);
        repeat (3) step(RemD, Col0C, 1'b1, 1'b0);
        check("plan_type_pre", bus.link_fault, 2'b00);
        step(RemD, Col0C, 1'b1, 1'b0);
        check("plan_type_remote", bus.tx_fault_ctrl, 2'b10);
        repeat (3) step(LocD, Col0C, 1'b1, 1'b0);
        check("plan_type_held", bus.link_fault, 2'b10);
        step(LocD, Col0C, 1'b1, 1'b0);
        check("plan_type_local", bus.link_fault, 2'b01);

        step(IdleD, IdleC, 1'b1, 1'b1);
        repeat (3) step(LocD, Col0C, 1'b1, 1'b0);
        repeat (64) step(IdleD, IdleC, 1'b1, 1'b0);
        step(LocD, Col0C, 1'b1, 1'b0);
        check("plan_window_expiry", bus.link_fault, 2'b00);
        repeat (8) step(ResD, Col0C, 1'b1, 1'b0);
        check("plan_reserved", bus.link_fault, 2'b00);

        step(IdleD, IdleC, 1'b1, 1'b1);
        repeat (4) step(LocD, Col0C, 1'b1, 1'b0);
        step(LocD, Col0C, 1'b1, 1'b1);
        check("plan_reset_mid_fault", bus.link_fault, 2'b00);
        repeat (3) step(LocD, Col0C, 1'b1, 1'b0);
        check("plan_after_reset", bus.link_fault, 2'b00);
        step(LocD, Col0C, 1'b1, 1'b0);
        step(LocD, Col0C, 1'b0, 1'b0);
        check("plan_disable", {1'b0, bus.fault_change}, 2'b01);

        fav = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) fav = $urandom_range(0, 1);
            if ($urandom_range(0, 99) == 0) begin
                repeat ($urandom_range(60, 70)) step(IdleD, IdleC, 1'b1, 1'b0);
            end
            rand_col(($urandom_range(0, 9) < 7) ? fav : $urandom_range(0, 5), d0, c0);
            rand_col(($urandom_range(0, 9) < 7) ? fav : $urandom_range(0, 5), d1, c1);
            step({d0, d1}, {c0, c1}, $urandom_range(0, 99) != 0, $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
